// File: rtl/clock_monitor_if.sv
// Status bundle between the clock divider side and clock_monitor: the three divided
// clocks in, per-channel lock/error flags and the combined lock out.
interface clock_monitor_if;
    logic clk_f;
    logic clk_2f;
    logic clk_4f;
    logic lock_f;
    logic lock_2f;
    logic lock_4f;
    logic lock_all;
    logic err_f;
    logic err_2f;
    logic err_4f;

    // Divider / environment side: drives the clocks, observes the status.
    modport master (
        output clk_f, clk_2f, clk_4f,
        input  lock_f, lock_2f, lock_4f, lock_all, err_f, err_2f, err_4f
    );

    // Monitor side.
    modport slave (
        input  clk_f, clk_2f, clk_4f,
        output lock_f, lock_2f, lock_4f, lock_all, err_f, err_2f, err_4f
    );
endinterface

// File: rtl/clock_monitor.sv
// Measures the high/low phases of three divided clocks in clk_in cycles and reports
// per-channel lock and error. Define CLKMON_STICKY_ERR_EN to make err_* sticky until reset.
module clkmon_channel #(
    parameter int D        = 32,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk_in,
    input  logic reset_L,
    input  logic i_x,
    output logic o_lock,
    output logic o_err
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] L_HALF = CNT_W'(D / 2);
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(D);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(D - 1);
    localparam logic [GW-1:0]    L_LOCK = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_x_q;
    logic             r_x_qq;
    logic [CNT_W-1:0] r_run_cnt;
    logic [GW-1:0]    r_good_cnt;
    logic [GW-1:0]    w_good_nxt;
    logic             r_err;
    logic             w_err_evt;
    logic             w_edge;
    logic             w_good;
    logic             w_timeout;

    assign w_edge    = r_x_q ^ r_x_qq;
    assign w_good    = (r_run_cnt == L_HALF);
    // The counter would hit D this cycle with no edge: an edge on that cycle wins.
    assign w_timeout = !w_edge && (r_run_cnt == L_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge reset_L) begin
        if (!reset_L) begin
            r_x_q     <= 1'b0;
            r_x_qq    <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_x_q  <= i_x;
            r_x_qq <= r_x_q;
            if (w_edge) begin
                r_run_cnt <= CNT_W'(1);
            end else if (r_run_cnt < L_FULL) begin
                r_run_cnt <= r_run_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
`ifdef CLKMON_STICKY_ERR_EN
            r_err      <= r_err | w_err_evt;
`else
            r_err      <= w_err_evt;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_err_evt   = 1'b0;
        unique case (r_state)
            ST_SEARCH: begin
                if (w_edge) begin
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    if (w_good) begin
                        w_good_nxt = r_good_cnt + GW'(1);
                        if (w_good_nxt == L_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        // A bad edge is still a valid phase reference, so keep measuring.
                        w_err_evt  = 1'b1;
                        w_good_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    if (!w_good) begin
                        w_err_evt   = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_MEASURE;
                    end
                end else if (w_timeout) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    assign o_lock = (r_state == ST_LOCKED);
    assign o_err  = r_err;
endmodule

module clock_monitor #(
    parameter int DF_1     = 32,
    parameter int DF_2     = 16,
    parameter int DF_4     = 8,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic           clk_in,
    input  logic           reset_L,
    clock_monitor_if.slave mon
);
    logic w_lock_f;
    logic w_lock_2f;
    logic w_lock_4f;
    logic r_lock_all;

    clkmon_channel #(.D(DF_1), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_ch_f (
        .clk_in  (clk_in),
        .reset_L (reset_L),
        .i_x     (mon.clk_f),
        .o_lock  (w_lock_f),
        .o_err   (mon.err_f)
    );

    clkmon_channel #(.D(DF_2), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_ch_2f (
        .clk_in  (clk_in),
        .reset_L (reset_L),
        .i_x     (mon.clk_2f),
        .o_lock  (w_lock_2f),
        .o_err   (mon.err_2f)
    );

    clkmon_channel #(.D(DF_4), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_ch_4f (
        .clk_in  (clk_in),
        .reset_L (reset_L),
        .i_x     (mon.clk_4f),
        .o_lock  (w_lock_4f),
        .o_err   (mon.err_4f)
    );

    always_ff @(posedge clk_in or negedge reset_L) begin
        if (!reset_L) begin
            r_lock_all <= 1'b0;
        end else begin
            r_lock_all <= w_lock_f & w_lock_2f & w_lock_4f;
        end
    end

    assign mon.lock_f   = w_lock_f;
    assign mon.lock_2f  = w_lock_2f;
    assign mon.lock_4f  = w_lock_4f;
    assign mon.lock_all = r_lock_all;
endmodule

// File: doc/clock_monitor.md
# clock_monitor

- Checks the three divided clocks (`clk_f`, `clk_2f`, `clk_4f`) against the master clock that produced them.
- Samples each clock as data in the `clk_in` domain and measures every high and low phase in `clk_in` cycles.
- Declares per-channel lock once phases repeatedly match the expected divisor, and flags short, long or stuck phases.
- Sits beside the clock generator and gates start-up of logic clocked by the divided clocks via `lock_all`.

## Interface
- `DF_1`, 32, divisor expected on `clk_f` (expected half-period 16)
- `DF_2`, 16, divisor expected on `clk_2f` (expected half-period 8)
- `DF_4`, 8, divisor expected on `clk_4f` (expected half-period 4)
- `LOCK_CNT`, 4, consecutive good half-periods required for lock
- `CNT_W`, 8, width of the phase counters; must hold `DF_1`
- `clk_in`  input  1  master clock; all logic on its rising edge
- `reset_L`  input  1  asynchronous, active-low reset
- `clk_f`, `clk_2f`, `clk_4f`  input  1 each  monitored clocks, synchronous to `clk_in`
- `lock_f`, `lock_2f`, `lock_4f`  output  1 each  channel locked
- `lock_all`  output  1  AND of the three lock outputs, registered
- `err_f`, `err_2f`, `err_4f`  output  1 each  channel error (see Configuration)

## Operation
- Three identical channel instances; X denotes the channel and D its divisor (`DF_1`, `DF_2` or `DF_4`).
- Input pipeline per channel: `x_q` is the registered input and `x_qq` is `x_q` delayed one cycle. An edge is `x_q != x_qq` (rise or fall).
- `run_cnt` (CNT_W bits) holds the number of cycles `x_q` has held its level.
  - On an edge: `run_cnt` is set to 1.
  - Otherwise: `run_cnt` increments, saturating at D.
- A run is "good" when, at an edge, `run_cnt == D/2`. Otherwise it is "bad".
- Channel FSM states:
  - SEARCH (reset state): lock=0. Any edge goes to MEASURE with `good_cnt` = 0. The first run is partial and is never checked.
  - MEASURE: lock=0.
    - Good edge: `good_cnt` increments. When it reaches `LOCK_CNT`, the FSM goes to LOCKED.
    - Bad edge: error event; `good_cnt` = 0; FSM stays in MEASURE, because the edge is a valid reference.
  - LOCKED: lock=1.
    - Good edge: FSM stays in LOCKED.
    - Bad edge: error event; FSM goes to MEASURE with `good_cnt` = 0.
- Timeout: in MEASURE or LOCKED, if `run_cnt` reaches D without an edge, an error event fires and the FSM goes to SEARCH. The event fires exactly once per stuck interval; SEARCH never raises errors.
- Arithmetic: all comparisons are unsigned at CNT_W bits. `good_cnt` is sized to hold `LOCK_CNT`.

## Timing
- Reset (async assert, released synchronously on the next `clk_in` edge):
  - All FSMs in SEARCH.
  - `run_cnt` = 0, `good_cnt` = 0, `x_q` = `x_qq` = 0.
  - All `lock_*`, `lock_all` and `err_*` = 0.
- Edge latency: a change on an input port is seen as an edge 2 cycles later (after the `x_q`, `x_qq` stages).
- `lock_X` rises in the cycle after the `LOCK_CNT`-th good edge, and falls in the cycle after a bad edge or a timeout.
- `lock_all` lags the individual locks by one cycle.
- An error event drives `err_X` starting the cycle after the edge or timeout.
- Simultaneous events:
  - An edge in the same cycle `run_cnt` would reach D counts as an edge, not a timeout.
  - Events on different channels are independent.
- Reset mid-operation clears locks and errors immediately (asynchronously).

## Configuration
- Macro: `CLKMON_STICKY_ERR_EN`.
  - Defined: `err_X` is set by an error event and held at 1 until `reset_L` is asserted.
  - Not defined: `err_X` is a one-cycle pulse per error event.
- Lock behaviour is identical in both builds.

## Test plan
- Drive the inputs from the divider with default divisors, release reset:
  - `lock_4f` rises 17 cycles after the first `clk_4f` edge is detected (4 good runs of 4).
  - `lock_2f` rises after 33 cycles, `lock_f` after 65.
  - `lock_all` rises the cycle after `lock_f`.
  - No `err_*` is ever asserted.
- From locked, shorten one `clk_f` high phase to 15 cycles:
  - `err_f` pulses once and `lock_f` drops.
  - `lock_f` returns after 4 further good half-periods (64 cycles).
  - Other channels are unaffected.
- From locked, hold `clk_2f` low: 16 cycles after the last edge, `err_2f` pulses once, `lock_2f` = 0, and the FSM is in SEARCH. Resuming toggling relocks after 1 + 4 edges.
- Lengthen one `clk_4f` low phase to 5 cycles: single `err_4f` pulse, and `lock_4f` drops for 4 half-periods.
- Assert `reset_L` = 0 mid-lock: all outputs go to 0 asynchronously. After release, the full relock sequence of the first test repeats.
- Build with `CLKMON_STICKY_ERR_EN`, inject the glitch from the second test: `err_f` stays 1 after relock until reset, and clears on `reset_L` = 0.
